// File: rtl/ctrl_hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding select
// codes, Tuse/Tnew classes, the shadow-record layouts and the helper functions.
package ctrl_hazard_pkg;

    typedef logic [4:0] reg_addr_t;
    typedef logic [1:0] tnew_t;
    typedef logic [1:0] tuse_t;
    typedef logic [1:0] fwd_sel_t;

    // Forwarding mux select codes (shared by D and E consumers)
    localparam fwd_sel_t FWD_GRF = 2'b00;
    localparam fwd_sel_t FWD_E   = 2'b01;
    localparam fwd_sel_t FWD_M   = 2'b10;
    localparam fwd_sel_t FWD_W   = 2'b11;

    // Tuse value meaning "operand not read"; it exceeds every Tnew so it never stalls
    localparam tuse_t TUSE_NONE = 2'd3;

    // Tnew classes at E entry, as produced by the decoder
    localparam tnew_t TNEW_ZERO = 2'd0;  // lui / jal / jalr
    localparam tnew_t TNEW_ALU  = 2'd1;
    localparam tnew_t TNEW_LOAD = 2'd2;

    // Shadow record of the instruction currently in E
    typedef struct packed {
        reg_addr_t rs;
        reg_addr_t rt;
        reg_addr_t a3;
        tnew_t     tnew;
    } e_rec_t;

    // Shadow record of the instruction currently in M
    typedef struct packed {
        reg_addr_t rt;
        reg_addr_t a3;
        tnew_t     tnew;
    } m_rec_t;

    // A producer matches a consumer register only if it writes it and it is not $0
    function automatic logic reg_match(input reg_addr_t a3, input reg_addr_t r);
        return (a3 == r) && (r != 5'd0);
    endfunction

    // One cycle of progress toward result availability, floored at zero
    function automatic tnew_t sat_dec(input tnew_t x);
        return (x == 2'd0) ? 2'd0 : tnew_t'(x - 2'd1);
    endfunction

endpackage

// File: rtl/ctrl_fwd_select.sv
// Forwarding select for one operand: picks the nearest younger producer whose
// result is already available. Producers still computing (tnew != 0) are
// skipped here because the stall logic holds the consumer back for them.
module ctrl_fwd_select
    import ctrl_hazard_pkg::*;
(
    input  logic [4:0] addr,
    input  logic       e_en,
    input  logic [4:0] e_a3,
    input  logic [1:0] e_tnew,
    input  logic [4:0] m_a3,
    input  logic [1:0] m_tnew,
    input  logic       w_en,
    input  logic [4:0] w_a3,
    output logic [1:0] sel
);

    // Nearest-stage-first priority over E, M, W
    always_comb begin
        // NOTE: default assignment first so no path through the block leaves sel unassigned (no latch).
        sel = FWD_GRF;
        if (e_en && reg_match(e_a3, addr) && (e_tnew == TNEW_ZERO)) begin
            sel = FWD_E;
        end else if (reg_match(m_a3, addr) && (m_tnew == TNEW_ZERO)) begin
            sel = FWD_M;
        end else if (w_en && reg_match(w_a3, addr)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/ctrl_hazard_unit.sv
// Stall/forward controller for the 5-stage MIPS pipeline.
// Keeps shadow records of the instructions in E, M and W, raises stall when a
// D-stage operand is needed before its producer can supply it, and otherwise
// drives the forwarding selects for D, E and M consumers.
// Build option: HAZARD_W_TO_D_FWD_EN lets the D-stage selects return the W
// code; without it the register file bypasses W->D itself and D sees 00.
module ctrl_hazard_unit
    import ctrl_hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_a3,
    input  logic [1:0] d_tnew,
    output logic       stall,
    output logic [1:0] d_fwd_rs,
    output logic [1:0] d_fwd_rt,
    output logic [1:0] e_fwd_rs,
    output logic [1:0] e_fwd_rt,
    output logic       m_fwd_rt
);

`ifdef HAZARD_W_TO_D_FWD_EN
    localparam logic D_W_FWD = 1'b1;
`else
    localparam logic D_W_FWD = 1'b0;
`endif

    e_rec_t    e_rec;
    m_rec_t    m_rec;
    reg_addr_t w_a3;

    logic stall_rs;
    logic stall_rt;

    // Operand needed earlier than the E or M producer can deliver it
    assign stall_rs = (reg_match(e_rec.a3, d_rs) && (e_rec.tnew > d_tuse_rs)) ||
                      (reg_match(m_rec.a3, d_rs) && (m_rec.tnew > d_tuse_rs));
    assign stall_rt = (reg_match(e_rec.a3, d_rt) && (e_rec.tnew > d_tuse_rt)) ||
                      (reg_match(m_rec.a3, d_rt) && (m_rec.tnew > d_tuse_rt));
    assign stall    = stall_rs | stall_rt;

    // Shift the shadow records; a stall injects a bubble into E while M and W advance
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every record samples the pre-edge state of its neighbour.
        if (reset) begin
            e_rec <= '0;
            m_rec <= '0;
            w_a3  <= '0;
        end else begin
            if (stall) begin
                e_rec <= '0;
            end else begin
                e_rec <= '{rs: d_rs, rt: d_rt, a3: d_a3, tnew: d_tnew};
            end
            m_rec <= '{rt: e_rec.rt, a3: e_rec.a3, tnew: sat_dec(e_rec.tnew)};
            w_a3  <= m_rec.a3;
        end
    end

    ctrl_fwd_select u_d_rs (
        .addr   (d_rs),
        .e_en   (1'b1),
        .e_a3   (e_rec.a3),
        .e_tnew (e_rec.tnew),
        .m_a3   (m_rec.a3),
        .m_tnew (m_rec.tnew),
        .w_en   (D_W_FWD),
        .w_a3   (w_a3),
        .sel    (d_fwd_rs)
    );

    ctrl_fwd_select u_d_rt (
        .addr   (d_rt),
        .e_en   (1'b1),
        .e_a3   (e_rec.a3),
        .e_tnew (e_rec.tnew),
        .m_a3   (m_rec.a3),
        .m_tnew (m_rec.tnew),
        .w_en   (D_W_FWD),
        .w_a3   (w_a3),
        .sel    (d_fwd_rt)
    );

    // E consumers have no younger E producer, so the E leg is disabled
    ctrl_fwd_select u_e_rs (
        .addr   (e_rec.rs),
        .e_en   (1'b0),
        .e_a3   (5'd0),
        .e_tnew (TNEW_ZERO),
        .m_a3   (m_rec.a3),
        .m_tnew (m_rec.tnew),
        .w_en   (1'b1),
        .w_a3   (w_a3),
        .sel    (e_fwd_rs)
    );

    ctrl_fwd_select u_e_rt (
        .addr   (e_rec.rt),
        .e_en   (1'b0),
        .e_a3   (5'd0),
        .e_tnew (TNEW_ZERO),
        .m_a3   (m_rec.a3),
        .m_tnew (m_rec.tnew),
        .w_en   (1'b1),
        .w_a3   (w_a3),
        .sel    (e_fwd_rt)
    );

    // Store data in M can only be refreshed from W
    assign m_fwd_rt = reg_match(w_a3, m_rec.rt);

endmodule
